// File: rtl/arm_mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: size codes, FSM states, read tag.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arm_mem_arbiter_pkg;

    // Access size codes as driven by the core on its data bus
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Arbiter FSM: a conflict costs exactly one extra memory slot (REPLAY)
    // and one quiet cycle (RELEASE) while the core re-presents stale requests.
    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_REPLAY  = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Describes the read issued last cycle so its returning word can be steered
    typedef struct packed {
        logic       vld;   // a read was issued last cycle
        logic       rom;   // 1 = fetch bus, 0 = data bus
        logic [1:0] size;  // access size of that read
        logic [1:0] lane;  // byte address bits [1:0] of that read
    } rd_tag_t;

endpackage

// File: rtl/arm_mem_lane.sv
// Byte-lane steering: byte enables plus write replication (READ=0) or read extraction (READ=1).
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module arm_mem_lane
    import arm_mem_arbiter_pkg::*;
#(
    parameter bit READ = 1'b0
) (
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_data
);

    // Memory word shifted so the addressed byte sits in bits [7:0]
    logic [31:0] w_shift;
    assign w_shift = i_data >> {i_addr, 3'b000};

    // Lane selection; anything that is not byte or half behaves as a full word
    always_comb begin
        o_be   = 4'b1111;
        o_data = i_data;
        case (i_size)
            MEM_B: begin
                o_be   = 4'b0001 << i_addr;
                o_data = READ ? {24'h0, w_shift[7:0]} : {4{i_data[7:0]}};
            end
            MEM_H: begin
                // Halfwords are taken as aligned; bit 0 of the address is dropped
                o_be   = i_addr[1] ? 4'b1100 : 4'b0011;
                o_data = READ ? {16'h0, (i_addr[1] ? i_data[31:16] : i_data[15:0])}
                              : {2{i_data[15:0]}};
            end
            default: begin
                o_be   = 4'b1111;
                o_data = i_data;
            end
        endcase
    end

endmodule

// File: rtl/arm_mem_arbiter.sv
// Arbitrates the core's fetch and data buses onto one single-port memory; data wins, fetch is replayed.
// Latency: read data 1 cycle after the request; a conflicted fetch returns 2 cycles after the request.
// Backpressure: freezes the core via o_core_en for the conflict and replay cycles.
// Optional: define ARB_CONFLICT_CNT_EN to add the saturating o_conflict_cnt output.
module arm_mem_arbiter
    import arm_mem_arbiter_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    output logic              o_core_en,
    input  logic              i_rom_en,
    input  logic [31:0]       i_rom_addr,
    output logic [31:0]       o_rom_data,
    input  logic              i_ram_en,
    input  logic              i_ram_wr,
    input  logic [1:0]        i_ram_size,
    input  logic [31:0]       i_ram_addr,
    input  logic [31:0]       i_ram_wdata,
    output logic [31:0]       o_ram_rdata,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [3:0]        o_mem_be,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       o_conflict_cnt
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic [MEM_AW-1:0] r_rep_addr;
    rd_tag_t           r_tag;
    logic [31:0]       r_rom_hold;
    logic [31:0]       r_ram_hold;

    logic              w_stall;
    logic              w_mem_en;
    logic              w_mem_wr;
    logic              w_is_rom;
    logic              w_latch;
    logic [1:0]        w_acc_size;
    logic [1:0]        w_acc_lane;
    logic [MEM_AW-1:0] w_mem_addr;

    logic [3:0]        w_wr_be;
    logic [31:0]       w_wr_data;
    logic [3:0]        w_unused_rd_be;
    logic [31:0]       w_rd_data;
    logic              w_unused_addr_bits;

    // Address bits outside the memory window wrap; low fetch bits are word-aligned away
    assign w_unused_addr_bits = ^{i_rom_addr[31:MEM_AW+2], i_rom_addr[1:0],
                                  i_ram_addr[31:MEM_AW+2]};

    // Next state and memory request; reset forces the idle, no-access picture at once
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_mem_en   = 1'b0;
        w_mem_wr   = 1'b0;
        w_is_rom   = 1'b0;
        w_latch    = 1'b0;
        w_acc_size = MEM_W;
        w_acc_lane = 2'b00;
        w_mem_addr = '0;
        case (r_state)
            ARB_IDLE: begin
                if (i_en && !rst) begin
                    if (i_ram_en) begin
                        w_mem_en   = 1'b1;
                        w_mem_wr   = i_ram_wr;
                        w_acc_size = i_ram_size;
                        w_acc_lane = i_ram_addr[1:0];
                        w_mem_addr = i_ram_addr[MEM_AW+1:2];
                        if (i_rom_en) begin
                            w_stall = 1'b1;
                            w_latch = 1'b1;
                            w_next  = ARB_REPLAY;
                        end
                    end else if (i_rom_en) begin
                        w_mem_en   = 1'b1;
                        w_is_rom   = 1'b1;
                        w_mem_addr = i_rom_addr[MEM_AW+1:2];
                    end
                end
            end
            ARB_REPLAY: begin
                w_mem_en   = 1'b1;
                w_is_rom   = 1'b1;
                w_mem_addr = r_rep_addr;
                w_stall    = 1'b1;
                w_next     = ARB_RELEASE;
            end
            ARB_RELEASE: begin
                // Core still shows the requests we just served; wait for it to advance
                if (i_en) begin
                    w_next = ARB_IDLE;
                end
            end
            default: begin
                w_next = ARB_IDLE;
            end
        endcase
    end

    arm_mem_lane #(.READ(1'b0)) u_wr_lane (
        .i_size (w_acc_size),
        .i_addr (w_acc_lane),
        .i_data (i_ram_wdata),
        .o_be   (w_wr_be),
        .o_data (w_wr_data)
    );

    arm_mem_lane #(.READ(1'b1)) u_rd_lane (
        .i_size (r_tag.size),
        .i_addr (r_tag.lane),
        .i_data (i_mem_rdata),
        .o_be   (w_unused_rd_be),
        .o_data (w_rd_data)
    );

    assign o_core_en   = i_en & ~w_stall;
    assign o_mem_en    = w_mem_en;
    assign o_mem_wr    = w_mem_wr;
    assign o_mem_be    = w_mem_en ? w_wr_be : 4'b0000;
    assign o_mem_addr  = w_mem_addr;
    assign o_mem_wdata = (w_mem_en && w_mem_wr) ? w_wr_data : 32'h0;

    // Returning read goes straight out on its bus; otherwise each bus shows its last read
    assign o_rom_data  = (r_tag.vld &&  r_tag.rom) ? w_rd_data : r_rom_hold;
    assign o_ram_rdata = (r_tag.vld && !r_tag.rom) ? w_rd_data : r_ram_hold;

    // FSM state, replay address and read tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_rep_addr <= '0;
            r_tag      <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_rep_addr <= i_rom_addr[MEM_AW+1:2];
            end
            r_tag.vld  <= w_mem_en & ~w_mem_wr;
            r_tag.rom  <= w_is_rom;
            r_tag.size <= w_acc_size;
            r_tag.lane <= w_acc_lane;
        end
    end

    // Hold registers keep read data visible until the next read on the same bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_hold <= 32'h0;
            r_ram_hold <= 32'h0;
        end else if (r_tag.vld) begin
            if (r_tag.rom) begin
                r_rom_hold <= w_rd_data;
            end else begin
                r_ram_hold <= w_rd_data;
            end
        end
    end

`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;

    // Count conflicts (entries into REPLAY), sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= 16'h0;
        end else if (r_state == ARB_IDLE && w_next == ARB_REPLAY &&
                     r_conflict_cnt != 16'hFFFF) begin
            r_conflict_cnt <= r_conflict_cnt + 16'h1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed bench for arm_mem_arbiter with a behavioural single-port memory model.
// Latency: checks outputs 3 time units after each rising edge.
// Backpressure: follows o_core_en by holding requests while the core is frozen.
module tb_arm_mem_arbiter;
    import arm_mem_arbiter_pkg::*;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_en;
    logic          o_core_en;
    logic          i_rom_en;
    logic [31:0]   i_rom_addr;
    logic [31:0]   o_rom_data;
    logic          i_ram_en;
    logic          i_ram_wr;
    logic [1:0]    i_ram_size;
    logic [31:0]   i_ram_addr;
    logic [31:0]   i_ram_wdata;
    logic [31:0]   o_ram_rdata;
    logic          o_mem_en;
    logic          o_mem_wr;
    logic [3:0]    o_mem_be;
    logic [AW-1:0] o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic [31:0]   mem_rdata = 32'h0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [int];

    always #5 clk = ~clk;

    arm_mem_arbiter #(.MEM_AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_en        (i_en),
        .o_core_en   (o_core_en),
        .i_rom_en    (i_rom_en),
        .i_rom_addr  (i_rom_addr),
        .o_rom_data  (o_rom_data),
        .i_ram_en    (i_ram_en),
        .i_ram_wr    (i_ram_wr),
        .i_ram_size  (i_ram_size),
        .i_ram_addr  (i_ram_addr),
        .i_ram_wdata (i_ram_wdata),
        .o_ram_rdata (o_ram_rdata),
        .o_mem_en    (o_mem_en),
        .o_mem_wr    (o_mem_wr),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] rd_word(input int a);
        if (mem.exists(a)) return mem[a];
        return 32'h0;
    endfunction

    // Synchronous memory macro model: preloaded while in reset, byte-lane writes
    always @(posedge clk) begin
        if (rst) begin
            mem[32'h04] = 32'h11112222;
            mem[32'h20] = 32'hCAFEF00D;
            mem[32'h40] = 32'hE3A00001;
            mem[32'h41] = 32'h0BADCAFE;
            mem[32'h81] = 32'h12345678;
        end else if (o_mem_en) begin
            if (o_mem_wr) begin
                logic [31:0] w;
                w = rd_word(int'(o_mem_addr));
                for (int b = 0; b < 4; b++)
                    if (o_mem_be[b]) w[8*b +: 8] = o_mem_wdata[8*b +: 8];
                mem[int'(o_mem_addr)] = w;
            end else begin
                mem_rdata <= rd_word(int'(o_mem_addr));
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_en = 1'b1;
        i_rom_en = 1'b0; i_rom_addr = 32'h0;
        i_ram_en = 1'b0; i_ram_wr = 1'b0; i_ram_size = MEM_W;
        i_ram_addr = 32'h0; i_ram_wdata = 32'h0;

        // Reset state
        tick(); tick(); #2;
        chk("rst_core_en", 32'(o_core_en), 32'h1);
        chk("rst_mem_en",  32'(o_mem_en),  32'h0);
        chk("rst_mem_be",  32'(o_mem_be),  32'h0);
        chk("rst_rom",     o_rom_data,     32'h0);
        chk("rst_ram",     o_ram_rdata,    32'h0);
        rst = 1'b0;

        // Fetch only at 0x100
        tick(); i_rom_en = 1'b1; i_rom_addr = 32'h100; #2;
        chk("f_be",      32'(o_mem_be),   32'hF);
        chk("f_addr",    32'(o_mem_addr), 32'h40);
        chk("f_wr",      32'(o_mem_wr),   32'h0);
        chk("f_core_en", 32'(o_core_en),  32'h1);
        tick(); i_rom_en = 1'b0; #2;
        chk("f_data",    o_rom_data,      32'hE3A00001);
        chk("f_idle_en", 32'(o_mem_en),   32'h0);
        // Address above the memory window wraps
        tick(); i_rom_en = 1'b1; i_rom_addr = 32'h0001_0104; #2;
        chk("wrap_addr", 32'(o_mem_addr), 32'h41);
        chk("f_hold",    o_rom_data,      32'hE3A00001);
        tick(); i_rom_en = 1'b0; #2;
        chk("wrap_data", o_rom_data,      32'h0BADCAFE);

        // Byte write 0xA5 to 0x203, then byte read back
        tick(); i_ram_en = 1'b1; i_ram_wr = 1'b1; i_ram_size = MEM_B;
        i_ram_addr = 32'h203; i_ram_wdata = 32'h123456A5; #2;
        chk("bw_be",    32'(o_mem_be),   32'h8);
        chk("bw_wdata", o_mem_wdata,     32'hA5A5A5A5);
        chk("bw_wr",    32'(o_mem_wr),   32'h1);
        chk("bw_addr",  32'(o_mem_addr), 32'h80);
        tick(); i_ram_wr = 1'b0; #2;
        chk("bw_noret", o_ram_rdata,     32'h0);
        chk("br_be",    32'(o_mem_be),   32'h8);
        tick(); i_ram_en = 1'b0; #2;
        chk("br_data",  o_ram_rdata,     32'h000000A5);

        // Halfword read at 0x206, then halfword write to 0x205
        tick(); i_ram_en = 1'b1; i_ram_wr = 1'b0; i_ram_size = MEM_H; i_ram_addr = 32'h206;
        tick(); i_ram_wr = 1'b1; i_ram_addr = 32'h205; i_ram_wdata = 32'h0000BEEF; #2;
        chk("hr_data",  o_ram_rdata,     32'h00001234);
        chk("hw_be",    32'(o_mem_be),   32'h3);
        chk("hw_wdata", o_mem_wdata,     32'hBEEFBEEF);
        tick(); i_ram_en = 1'b0; i_ram_wr = 1'b0; #2;
        chk("hw_noret", o_ram_rdata,     32'h00001234);

        // Conflict: fetch 0x10 and word read 0x80 together
        tick(); i_rom_en = 1'b1; i_rom_addr = 32'h10;
        i_ram_en = 1'b1; i_ram_size = MEM_W; i_ram_addr = 32'h80; #2;
        chk("c0_core_en", 32'(o_core_en),  32'h0);
        chk("c0_addr",    32'(o_mem_addr), 32'h20);
        chk("c0_mem_en",  32'(o_mem_en),   32'h1);
        tick(); #2;
        chk("c1_core_en", 32'(o_core_en),  32'h0);
        chk("c1_addr",    32'(o_mem_addr), 32'h04);
        chk("c1_be",      32'(o_mem_be),   32'hF);
        chk("c1_ram",     o_ram_rdata,     32'hCAFEF00D);
        tick(); #2;
        chk("c2_core_en", 32'(o_core_en),  32'h1);
        chk("c2_mem_en",  32'(o_mem_en),   32'h0);
        chk("c2_be",      32'(o_mem_be),   32'h0);
        chk("c2_rom",     o_rom_data,      32'h11112222);
        tick(); i_rom_en = 1'b0; i_ram_en = 1'b0; #2;
        chk("c3_rom_hold", o_rom_data,     32'h11112222);
        chk("c3_ram_hold", o_ram_rdata,    32'hCAFEF00D);

        // Conflict with i_en dropping during REPLAY
        i_rom_en = 1'b1; i_rom_addr = 32'h104;
        i_ram_en = 1'b1; i_ram_size = MEM_W; i_ram_addr = 32'h204; #1;
        chk("e0_core_en", 32'(o_core_en),  32'h0);
        tick(); i_en = 1'b0; #2;
        chk("e1_mem_en",  32'(o_mem_en),   32'h1);
        chk("e1_addr",    32'(o_mem_addr), 32'h41);
        chk("e1_ram",     o_ram_rdata,     32'h1234BEEF);
        tick(); #2;
        chk("e2_rom",     o_rom_data,      32'h0BADCAFE);
        chk("e2_mem_en",  32'(o_mem_en),   32'h0);
        chk("e2_core_en", 32'(o_core_en),  32'h0);
        tick(); #2;
        chk("e3_mem_en",  32'(o_mem_en),   32'h0);
        chk("e3_core_en", 32'(o_core_en),  32'h0);
        i_en = 1'b1; #1;
        chk("e4_core_en", 32'(o_core_en),  32'h1);
        chk("e4_mem_en",  32'(o_mem_en),   32'h0);
        tick(); i_rom_addr = 32'h100; i_ram_en = 1'b0; #2;
        chk("e5_mem_en",  32'(o_mem_en),   32'h1);
        chk("e5_addr",    32'(o_mem_addr), 32'h40);
        tick(); i_rom_en = 1'b0; #2;
        chk("e6_rom",     o_rom_data,      32'hE3A00001);

        // Reset asserted during REPLAY
        tick(); i_rom_en = 1'b1; i_rom_addr = 32'h10;
        i_ram_en = 1'b1; i_ram_size = MEM_W; i_ram_addr = 32'h80;
        tick(); #2;
        chk("r0_mem_en",  32'(o_mem_en),   32'h1);
        rst = 1'b1; #1;
        chk("r1_mem_en",  32'(o_mem_en),    32'h0);
        chk("r1_mem_wr",  32'(o_mem_wr),    32'h0);
        chk("r1_be",      32'(o_mem_be),    32'h0);
        chk("r1_addr",    32'(o_mem_addr),  32'h0);
        chk("r1_wdata",   o_mem_wdata,      32'h0);
        chk("r1_rom",     o_rom_data,       32'h0);
        chk("r1_ram",     o_ram_rdata,      32'h0);
        chk("r1_core_en", 32'(o_core_en),   32'h1);
        i_rom_en = 1'b0; i_ram_en = 1'b0;
        tick(); #2; rst = 1'b0;
        tick(); #2;
        chk("r2_mem_en",  32'(o_mem_en),   32'h0);
        chk("r2_rom",     o_rom_data,      32'h0);
        i_rom_en = 1'b1; i_rom_addr = 32'h10; #1;
        chk("r3_mem_en",  32'(o_mem_en),   32'h1);
        chk("r3_addr",    32'(o_mem_addr), 32'h04);
        chk("r3_core_en", 32'(o_core_en),  32'h1);
        tick(); i_rom_en = 1'b0; #2;
        chk("r4_rom",     o_rom_data,      32'h11112222);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
